// File: rtl/nf_i_du_pipe.sv
// RV32I decode stage with branch resolution at decode and a valid/ready output FIFO.
// Optional write-back forwarding into operand compares: define NF_DU_FWD_EN.
module nf_i_du_pipe #(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ext_data,
    output logic            srcB_sel,
    output logic [3:0]      alu_op,
    output logic [4:0]      shamt,
    output logic [4:0]      wa3,
    output logic            we_rf,
    output logic            we_dm,
    output logic            rf_src,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] F7Alt     = 7'b0100000;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4, AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
    localparam logic [3:0] AluOr = 4'd8, AluAnd = 4'd9, AluPassB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] ext_data;
        logic            src_b;
        logic [3:0]      alu_op;
        logic [4:0]      shamt;
        logic [4:0]      wa3;
        logic            we_rf;
        logic            we_dm;
        logic            rf_src;
        logic            br_taken;
        logic [XLEN-1:0] br_target;
        logic            illegal;
    } entry_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ext_i, ext_s, ext_b, ext_u;
    logic [XLEN-1:0] op_a, op_b;
    logic            cmp_eq, cmp_lt, cmp_ltu, legal;
    entry_t          dec;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign ra1    = instr[19:15];
    assign ra2    = instr[24:20];

    assign ext_i = XLEN'($signed(instr[31:20]));
    assign ext_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign ext_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign ext_u = XLEN'($signed({instr[31:12], 12'b0}));

`ifdef NF_DU_FWD_EN
    // x0 is never forwarded: a write-back to x0 is architecturally discarded.
    assign op_a = (wb_we && wb_wa == ra1 && ra1 != 5'd0) ? wb_wd : rd1;
    assign op_b = (wb_we && wb_wa == ra2 && ra2 != 5'd0) ? wb_wd : rd2;
`else
    logic unused_wb;
    assign op_a      = rd1;
    assign op_b      = rd2;
    assign unused_wb = ^{wb_we, wb_wa, wb_wd};
`endif

    assign cmp_eq  = (op_a == op_b);
    assign cmp_lt  = ($signed(op_a) < $signed(op_b));
    assign cmp_ltu = (op_a < op_b);

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OpcOp: begin
                dec.we_rf = 1'b1;
                if (funct7 == F7Alt) begin
                    legal      = (funct3 == 3'b000) || (funct3 == 3'b101);
                    dec.alu_op = alu_of(funct3, 1'b1);
                end else begin
                    legal      = (funct7 == 7'b0);
                    dec.alu_op = alu_of(funct3, 1'b0);
                end
            end
            OpcOpImm: begin
                dec.we_rf    = 1'b1;
                dec.src_b    = 1'b1;
                dec.ext_data = ext_i;
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0) || (funct7 == F7Alt);
                end
                // Only the right shift honours funct7; ADDI has no SUB form.
                dec.alu_op = alu_of(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OpcLui: begin
                dec.we_rf    = 1'b1;
                dec.src_b    = 1'b1;
                dec.ext_data = ext_u;
                dec.alu_op   = AluPassB;
            end
            OpcLoad: begin
                legal        = (funct3 == 3'b010);
                dec.we_rf    = 1'b1;
                dec.rf_src   = 1'b1;
                dec.src_b    = 1'b1;
                dec.ext_data = ext_i;
            end
            OpcStore: begin
                legal        = (funct3 == 3'b010);
                dec.we_dm    = 1'b1;
                dec.src_b    = 1'b1;
                dec.ext_data = ext_s;
            end
            OpcBranch: begin
                dec.alu_op   = AluSub;
                dec.ext_data = ext_b;
                case (funct3)
                    3'b000:  dec.br_taken = cmp_eq;
                    3'b001:  dec.br_taken = !cmp_eq;
                    3'b100:  dec.br_taken = cmp_lt;
                    3'b101:  dec.br_taken = !cmp_lt;
                    3'b110:  dec.br_taken = cmp_ltu;
                    3'b111:  dec.br_taken = !cmp_ltu;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.shamt     = instr[24:20];
        dec.wa3       = instr[11:7];
        dec.br_target = pc + ext_b;
    end

    logic [AW:0] wp_q, rp_q;
    entry_t      mem_q [BUF_DEPTH];
    entry_t      head, out_e;
    logic        full, enq, deq;

    assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign out_valid = (wp_q != rp_q);
    assign in_ready  = !full;
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (enq) begin
                mem_q[wp_q[AW-1:0]] <= dec;
                wp_q                <= wp_q + {{AW{1'b0}}, 1'b1};
            end
            if (deq) rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
        end
    end

    assign head  = mem_q[rp_q[AW-1:0]];
    assign out_e = out_valid ? head : '0;

    assign ext_data  = out_e.ext_data;
    assign srcB_sel  = out_e.src_b;
    assign alu_op    = out_e.alu_op;
    assign shamt     = out_e.shamt;
    assign wa3       = out_e.wa3;
    assign we_rf     = out_e.we_rf;
    assign we_dm     = out_e.we_dm;
    assign rf_src    = out_e.rf_src;
    assign br_taken  = out_e.br_taken;
    assign br_target = out_e.br_target;
    assign illegal   = out_e.illegal;
endmodule

// File: tb/tb_nf_i_du_pipe.sv
// Directed bench for nf_i_du_pipe: expected entries are queued on accept and checked at the head.
module tb_nf_i_du_pipe;
    typedef struct packed {
        logic [31:0] ext_data;
        logic        src_b;
        logic [3:0]  alu_op;
        logic [4:0]  shamt;
        logic [4:0]  wa3;
        logic        we_rf;
        logic        we_dm;
        logic        rf_src;
        logic        br_taken;
        logic [31:0] br_target;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] instr = '0, pc = '0, rd1 = '0, rd2 = '0, wb_wd = '0;
    logic [4:0]  ra1, ra2, wb_wa = '0, shamt, wa3;
    logic        wb_we = 1'b0, srcB_sel, we_rf, we_dm, rf_src, br_taken, illegal;
    logic [31:0] ext_data, br_target;
    logic [3:0]  alu_op;

    exp_t        q[$];
    exp_t        exp_cur, obs;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    nf_i_du_pipe #(.BUF_DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ext_data(ext_data),
        .srcB_sel(srcB_sel), .alu_op(alu_op), .shamt(shamt), .wa3(wa3),
        .we_rf(we_rf), .we_dm(we_dm), .rf_src(rf_src), .br_taken(br_taken),
        .br_target(br_target), .illegal(illegal)
    );

    assign obs = '{ext_data, srcB_sel, alu_op, shamt, wa3, we_rf, we_dm, rf_src, br_taken,
                   br_target, illegal};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Raw fields (shamt, wa3, branch target) follow the instruction bits for every entry.
    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] p,
                                input logic [31:0] ext, input logic sb, input logic [3:0] op,
                                input logic wrf, input logic wdm, input logic src,
                                input logic bt, input logic ill);
        logic [31:0] bimm;
        bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return '{ext, sb, op, ins[24:20], ins[11:7], wrf, wdm, src, bt, p + bimm, ill};
    endfunction

    task automatic put(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
        instr = ins; pc = p; rd1 = a; rd2 = b; in_valid = 1'b1; exp_cur = e;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
                chk("head", obs, q[0]);
                if (out_ready && !flush) void'(q.pop_front());
            end
        end else begin
            chk("idle_zero", obs, '0);
        end
        if (in_valid && in_ready && !flush) q.push_back(exp_cur);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() != 0; i++) cyc();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fields", obs, '0);
        resetn    = 1'b1;
        out_ready = 1'b1;

        // ADDI x5,x1,-1
        put(32'hFFF08293, 32'h100, 0, 0, mk(32'hFFF08293, 32'h100, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0));
        #1;
        chk("ra1", ra1, 5'd1);
        chk("ra2", ra2, 5'd31);
        cyc();
        chk("addi_latency", out_valid, 1'b1);
        chk("addi_target", br_target, 32'hE4);
        // BLT / BLTU with rd1=-1, rd2=1 back to back
        put(32'h0020C463, 32'h40, 32'hFFFFFFFF, 1, mk(32'h0020C463, 32'h40, 8, 0, 1, 0, 0, 0, 1, 0));
        cyc();
        chk("blt_taken", br_taken, 1'b1);
        chk("blt_target", br_target, 32'h48);
        put(32'h0020E463, 32'h40, 32'hFFFFFFFF, 1, mk(32'h0020E463, 32'h40, 8, 0, 1, 0, 0, 0, 0, 0));
        cyc();
        chk("bltu_taken", br_taken, 1'b0);
        // BEQ x1,x2 with write-back to x1 carrying the rd2 value
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'd5;
`ifdef NF_DU_FWD_EN
        put(32'h00208463, 32'h80, 0, 5, mk(32'h00208463, 32'h80, 8, 0, 1, 0, 0, 0, 1, 0));
`else
        put(32'h00208463, 32'h80, 0, 5, mk(32'h00208463, 32'h80, 8, 0, 1, 0, 0, 0, 0, 0));
`endif
        cyc();
        // BEQ x0,x2 with write-back targeting x0: never forwarded
        wb_wa = 5'd0;
        put(32'h00200463, 32'h84, 0, 5, mk(32'h00200463, 32'h84, 8, 0, 1, 0, 0, 0, 0, 0));
        cyc();
        wb_we = 1'b0;
        put(32'h0020A423, 32'h88, 0, 0, mk(32'h0020A423, 32'h88, 8, 1, 0, 0, 1, 0, 0, 0));
        cyc();
        put(32'h123453B7, 32'h8C, 0, 0, mk(32'h123453B7, 32'h8C, 32'h12345000, 1, 10, 1, 0, 0, 0, 0));
        cyc();
        put(32'h4030D413, 32'h90, 0, 0, mk(32'h4030D413, 32'h90, 32'h403, 1, 7, 1, 0, 0, 0, 0));
        cyc();
        put(32'h022081B3, 32'h94, 0, 0, mk(32'h022081B3, 32'h94, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc();
        put(32'h0020A463, 32'h98, 0, 0, mk(32'h0020A463, 32'h98, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc();
        put(32'h0000007F, 32'h9C, 0, 0, mk(32'h0000007F, 32'h9C, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc();
        chk("illegal_flag", illegal, 1'b1);
        chk("illegal_wr", {we_rf, we_dm, br_taken}, 3'b000);
        drain();

        // Back-pressure: two accepts fill the FIFO, third waits
        out_ready = 1'b0;
        put(32'h002081B3, 32'h200, 0, 0, mk(32'h002081B3, 32'h200, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc();
        put(32'h40208233, 32'h204, 0, 0, mk(32'h40208233, 32'h204, 0, 0, 1, 1, 0, 0, 0, 0));
        cyc();
        chk("full_in_ready", in_ready, 1'b0);
        put(32'h0040A303, 32'h208, 0, 0, mk(32'h0040A303, 32'h208, 4, 1, 0, 1, 0, 1, 0, 0));
        cyc();
        chk("still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("ready_after_pop", in_ready, 1'b1);
        cyc();
        drain();

        // Flush while full, with an instruction offered
        out_ready = 1'b0;
        put(32'h002081B3, 32'h300, 0, 0, mk(32'h002081B3, 32'h300, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        q.delete();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        // Flush with one entry, ready input and ready output: nothing captured or consumed
        put(32'h002081B3, 32'h310, 0, 0, mk(32'h002081B3, 32'h310, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc();
        out_ready = 1'b1; flush = 1'b1;
        cyc();
        q.delete();
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk("flush1_valid", out_valid, 1'b0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        put(32'h002081B3, 32'h400, 0, 0, mk(32'h002081B3, 32'h400, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc();
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 1'b1);
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        cyc();
        chk("post_reset_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nf_i_du_pipe.md
# nf_i_du_pipe

Registered, handshaked RV32I decode stage; successor to the combinational decode unit. It decodes one instruction per cycle, resolves all six branch conditions at decode, and can bypass the write-back result into operand compares. Results go into a parametrised output FIFO, so fetch and execute are decoupled by valid/ready flow control. It sits between the fetch stage and the execute/ALU stage of the pipelined core.

## Interface
- BUF_DEPTH, 2: output FIFO entries; power of two, ≥2
- XLEN, 32: PC and operand width
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  instr/pc valid
- in_ready  out  1  = !full
- instr  in  32  instruction word
- pc  in  XLEN  instruction address
- ra1, ra2  out  5  combinational instr[19:15], instr[24:20]
- rd1, rd2  in  XLEN  register file read data, same cycle as ra1/ra2
- wb_we, wb_wa[4:0], wb_wd[XLEN-1:0]  in  write-back port (used only with forwarding)
- flush  in  1  synchronous pipeline kill
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  execute accepts head
- ext_data  out  XLEN  sign-extended immediate
- srcB_sel  out  1  1 = immediate to ALU B
- alu_op  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
- shamt  out  5  instr[24:20]
- wa3  out  5  instr[11:7]
- we_rf, we_dm, rf_src  out  1  reg write, mem write, 1 = load data to RF
- br_taken  out  1  branch resolved taken
- br_target  out  XLEN  pc + B-immediate, modulo 2^XLEN
- illegal  out  1  unsupported encoding

## Operation
- Decoded opcodes: OP 0110011, OP-IMM 0010011, LUI 0110111 (alu_op PASSB, ext_data = imm20<<12), LW 0000011 (funct3=010), SW 0100011 (funct3=010), BRANCH 1100011.
- OP: funct7 0100000 selects SUB/SRA, otherwise 0000000 is required. OP-IMM shifts use the funct7 rule. SLLI/SRLI/SRAI set srcB_sel=1 and take shamt.
- Immediates: I, S, B (bit0=0) and U. Sign bit is instr[31].
- Branch funct3 mapping: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu. 010/011 are illegal.
- Any other opcode, funct3 or funct7 sets illegal=1 and forces we_rf, we_dm, br_taken to 0. The entry is still queued.
- Enqueue when in_valid && in_ready && !flush. Dequeue when out_valid && out_ready.
- Simultaneous enqueue and dequeue while full is not allowed: in_ready stays low when full.
- Read/write pointers are log2(BUF_DEPTH)+1 bits with wrap bit. Full = MSBs differ and low bits equal.
- flush clears the FIFO on the same edge and blocks that cycle's enqueue. The dequeue handshake in that cycle is void.
- While out_valid=0, all output fields are driven 0.

## Timing
- Reset: pointers 0, out_valid 0, in_ready 1, all stored fields 0.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous).
- Latency: accepted at edge N, out_valid=1 after edge N.
- Throughput: 1 instr/cycle with out_ready held high.
- Operand compare and forwarding are combinational in the accept cycle. Values are captured into the entry.
- The head entry is stable while out_valid && !out_ready.

## Configuration
- NF_DU_FWD_EN defined: each operand uses wb_wd when wb_we && wb_wa==ra && ra!=0, otherwise rd1/rd2.
- NF_DU_FWD_EN undefined: rd1/rd2 are used directly and the wb_* ports are ignored (left unconnected-safe).

## Test plan
- ADDI x5,x1,-1 (0xFFF08293), pc=0x100 -> one cycle later: out_valid=1, alu_op=0, srcB_sel=1, ext_data=0xFFFFFFFF, wa3=5, we_rf=1, illegal=0.
- BLT x1,x2,+8 with rd1=0xFFFFFFFF, rd2=1, pc=0x40 -> br_taken=1, br_target=0x48. Same with BLTU -> br_taken=0.
- out_ready=0, three back-to-back instrs, BUF_DEPTH=2 -> in_ready=0 after two accepts. Releasing out_ready yields the instrs in order, third accepted next.
- FIFO holding 2 entries, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming instr not captured.
- NF_DU_FWD_EN: BEQ x1,x2, rd1=0, rd2=5, wb_we=1, wb_wa=1, wb_wd=5 -> br_taken=1. Same with wb_wa=0 targeting x0 -> br_taken=0.
- instr=0x0000007F -> illegal=1, we_rf=0, we_dm=0, br_taken=0.
